// File: rtl/password_attempt_controller.sv
// password_attempt_controller: sequences password compare requests, counts misses, enforces timed lockout.
// Optional lockout escalation: define LOCK_ESCALATE_EN.  Rev 1.0
`default_nettype none

module password_attempt_controller #(
  parameter int PW_W         = 18,
  parameter int MAX_FAIL     = 3,
  parameter int LOCK_CYCLES  = 16,
  parameter int GRANT_CYCLES = 8,
  parameter int TIMEOUT      = 15
) (
  input  logic                            key,
  input  logic                            reset,
  input  logic [PW_W-1:0]                 s,
  input  logic                            submit,
  output logic                            chk_start,
  output logic [PW_W-1:0]                 chk_data,
  input  logic                            chk_valid,
  input  logic                            chk_match,
  output logic                            unlock,
  output logic                            locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [2:0]                      state_code
);

  localparam int FW       = $clog2(MAX_FAIL + 1);
  localparam int LOCK_MAX = LOCK_CYCLES * 8;
  localparam int TMAX_A   = (TIMEOUT > GRANT_CYCLES) ? TIMEOUT : GRANT_CYCLES;
  localparam int TMAX     = (TMAX_A > LOCK_MAX) ? TMAX_A : LOCK_MAX;
  localparam int TW       = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TIMEOUT_T    = TW'(TIMEOUT);
  localparam logic [TW-1:0] GRANT_LAST   = TW'(GRANT_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_BASE    = TW'(LOCK_CYCLES);
  localparam logic [FW-1:0] FAIL_SAT     = FW'(MAX_FAIL);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] GRANT = 3'd2;
  localparam logic [2:0] FAIL  = 3'd3;
  localparam logic [2:0] LOCK  = 3'd4;

  logic [2:0]    state;
  logic          submit_q;
  logic          sub_edge;
  logic [TW-1:0] timer;
  logic [TW-1:0] lock_len;
  logic          lock_done;
  logic          last_fail;

  assign sub_edge   = submit & ~submit_q;
  assign lock_done  = (state == LOCK) && (timer == lock_len - TW'(1));
  assign last_fail  = (int'(fail_cnt) + 1 == MAX_FAIL);
  assign state_code = state;

  always_ff @(posedge key or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      submit_q  <= 1'b0;
      chk_start <= 1'b0;
      chk_data  <= '0;
      unlock    <= 1'b0;
      locked    <= 1'b0;
      fail_cnt  <= '0;
      timer     <= '0;
    end else begin
      submit_q  <= submit;
      chk_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sub_edge) begin
            chk_data  <= s;
            chk_start <= 1'b1;
            timer     <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A result strobe takes priority over an expiring timeout.
          if (chk_valid && chk_match) begin
            unlock   <= 1'b1;
            fail_cnt <= '0;
            timer    <= '0;
            state    <= GRANT;
          end else if (chk_valid || (timer == TIMEOUT_T)) begin
            timer <= '0;
            if (last_fail) begin
              locked   <= 1'b1;
              fail_cnt <= FAIL_SAT;
              state    <= LOCK;
            end else begin
              fail_cnt <= fail_cnt + FW'(1);
              state    <= FAIL;
            end
          end else if (!chk_start) begin
            timer <= timer + TW'(1);
          end
        end
        GRANT: begin
          if (timer == GRANT_LAST) begin
            unlock <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        FAIL: begin
          state <= IDLE;
        end
        LOCK: begin
          if (lock_done) begin
            locked   <= 1'b0;
            fail_cnt <= '0;
            state    <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LOCK_ESCALATE_EN
  localparam logic [TW-1:0] LOCK_TOP  = TW'(LOCK_MAX);
  localparam logic [TW-1:0] LOCK_HALF = TW'(LOCK_MAX / 2);

  logic grant_enter;
  assign grant_enter = (state == WAIT) && chk_valid && chk_match;

  // Each completed lockout doubles the next one until a successful match.
  always_ff @(posedge key or negedge reset) begin
    if (!reset) begin
      lock_len <= LOCK_BASE;
    end else if (grant_enter) begin
      lock_len <= LOCK_BASE;
    end else if (lock_done) begin
      lock_len <= (lock_len >= LOCK_HALF) ? LOCK_TOP : (lock_len << 1);
    end
  end
`else
  assign lock_len = LOCK_BASE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_password_attempt_controller.sv
// Scoreboard bench for password_attempt_controller: stimulus queues expectations, a monitor pops and compares.
`default_nettype none

module tb_password_attempt_controller;

  logic        key = 1'b0;
  logic        reset;
  logic [17:0] s;
  logic        submit;
  logic        chk_start;
  logic [17:0] chk_data;
  logic        chk_valid;
  logic        chk_match;
  logic        unlock;
  logic        locked;
  logic [1:0]  fail_cnt;
  logic [2:0]  state_code;

  password_attempt_controller dut (
    .key(key), .reset(reset), .s(s), .submit(submit),
    .chk_start(chk_start), .chk_data(chk_data),
    .chk_valid(chk_valid), .chk_match(chk_match),
    .unlock(unlock), .locked(locked),
    .fail_cnt(fail_cnt), .state_code(state_code)
  );

  always #5 key = ~key;

  typedef struct {
    int code;  // 1 = compare request, 2/3/4 = outcome state
    int data;
    int fcnt;
    int dur;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(negedge key);
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0, start_cyc = 0, prev_code = 0, run_len = 0, cur_dur = 0;
  bit   in_run = 0;
  exp_t me;

  always @(negedge key) begin
    cyc++;
    if (!reset) begin
      prev_code = 0;
      in_run    = 0;
    end else begin
      chk("flags", int'({unlock, locked}), int'({state_code == 3'd2, state_code == 3'd4}));
      if (chk_start) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("start_kind", 1, me.code);
          chk("chk_data", int'(chk_data), me.data);
        end
      end
      if (in_run && int'(state_code) != prev_code) begin
        chk("duration", run_len, cur_dur);
        chk("exit_state", int'(state_code), 0);
        if (prev_code == 4) chk("fail_cnt_after_lock", int'(fail_cnt), 0);
        in_run = 0;
      end else if (in_run) begin
        run_len++;
      end
      if (int'(state_code) != prev_code && state_code >= 3'd2) begin
        if (exp_q.size() == 0) chk("unexpected_result", int'(state_code), 0);
        else begin
          me = exp_q.pop_front();
          chk("result_state", int'(state_code), me.code);
          chk("result_fail_cnt", int'(fail_cnt), me.fcnt);
          chk("result_latency", cyc - start_cyc, me.lat);
          cur_dur = me.dur;
          run_len = 1;
          in_run  = 1;
        end
      end
      prev_code = int'(state_code);
    end
  end

  // ---------------- stimulus ----------------
  // dly < 0 means the checker never answers.
  task automatic attempt(input logic [17:0] val, input int dly, input logic m, input bit hold,
                         input int code, input int fcnt, input int dur, input int lat);
    int n;
    exp_q.push_back('{1, int'(val), 0, 0, 0});
    exp_q.push_back('{code, 0, fcnt, dur, lat});
    s = val;
    submit = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!chk_start && n < 10);
    if (!chk_start) chk("start_wait_expired", 0, 1);
    s = ~val;
    if (!hold) submit = 1'b0;
    if (dly >= 0) begin
      repeat (dly) tick();
      chk_valid = 1'b1;
      chk_match = m;
      tick();
      chk_valid = 1'b0;
      chk_match = 1'b0;
    end
    n = 0;
    while (state_code == 3'd1 && n < 40) begin tick(); n++; end
    if (state_code == 3'd1) chk("result_wait_expired", 1, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state_code != 3'd0 && n < 300) begin tick(); n++; end
    if (state_code != 3'd0) chk("idle_wait_expired", int'(state_code), 0);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; submit = 1'b0; s = '0; chk_valid = 1'b0; chk_match = 1'b0;
    repeat (3) tick();
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_chk_start", int'(chk_start), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);
    chk("rst_state", int'(state_code), 0);
    chk("rst_chk_data", int'(chk_data), 0);
    reset = 1'b1;
    tick();

    // Match two cycles after the request.
    attempt(18'h2A5A5, 2, 1'b1, 0, 2, 0, 8, 3);
    wait_idle();

    // Three misses lock the controller; submits during lockout are dropped.
    attempt(18'h0FFFF, 2, 1'b0, 0, 3, 1, 1, 3);
    wait_idle();
    attempt(18'h0FFFF, 2, 1'b0, 0, 3, 2, 1, 3);
    wait_idle();
    attempt(18'h0FFFF, 2, 1'b0, 0, 4, 3, 16, 3);
    repeat (3) begin submit = 1'b1; tick(); submit = 1'b0; tick(); end
    chk("locked_during_lock", int'(locked), 1);
    wait_idle();

    // No checker answer: forced failure.
    attempt(18'h00001, -1, 1'b0, 0, 3, 1, 1, 17);
    wait_idle();

    // Answer arrives in the same cycle the timeout would fire: the answer wins.
    attempt(18'h1C3C3, 16, 1'b1, 0, 2, 0, 8, 17);
    wait_idle();

    // Stray checker strobe while idle must do nothing.
    chk_valid = 1'b1; chk_match = 1'b1; tick(); chk_valid = 1'b0; chk_match = 1'b0;
    repeat (3) tick();
    chk("stray_valid_state", int'(state_code), 0);

    // Submit held high: one request only, captured word stays put.
    attempt(18'h13579, 2, 1'b1, 1, 2, 0, 8, 3);
    chk("chk_data_stable", int'(chk_data), 18'h13579);
    repeat (30) tick();
    submit = 1'b0;
    wait_idle();

    // Reset in the fifth lockout cycle.
    attempt(18'h0FFFF, 2, 1'b0, 0, 3, 1, 1, 3);
    wait_idle();
    attempt(18'h0FFFF, 2, 1'b0, 0, 3, 2, 1, 3);
    wait_idle();
    attempt(18'h0FFFF, 2, 1'b0, 0, 4, 3, 16, 3);
    repeat (4) tick();
    chk("locked_before_reset", int'(locked), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_fail_cnt", int'(fail_cnt), 0);
    chk("mid_rst_chk_start", int'(chk_start), 0);
    chk("mid_rst_state", int'(state_code), 0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_state", int'(state_code), 0);

    // Failure count restarts from zero after reset.
    attempt(18'h0FFFF, 2, 1'b0, 0, 3, 1, 1, 3);
    wait_idle();
    attempt(18'h2A5A5, 1, 1'b1, 0, 2, 0, 8, 2);
    wait_idle();

`ifdef LOCK_ESCALATE_EN
    for (int r = 0; r < 3; r++) begin
      attempt(18'h0FFFF, 2, 1'b0, 0, (r == 2) ? 4 : 3, r + 1, (r == 2) ? 16 : 1, 3);
      wait_idle();
    end
    for (int r = 0; r < 3; r++) begin
      attempt(18'h0FFFF, 2, 1'b0, 0, (r == 2) ? 4 : 3, r + 1, (r == 2) ? 32 : 1, 3);
      wait_idle();
    end
    attempt(18'h2A5A5, 2, 1'b1, 0, 2, 0, 8, 3);
    wait_idle();
    for (int r = 0; r < 3; r++) begin
      attempt(18'h0FFFF, 2, 1'b0, 0, (r == 2) ? 4 : 3, r + 1, (r == 2) ? 16 : 1, 3);
      wait_idle();
    end
`endif

    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
